// File: rtl/formatter_pkg.sv
// Shared types and constants for the packet formatter.
package formatter_pkg;

  localparam int unsigned MAX_LEN = 32;
  localparam logic [1:0]  NO_CH   = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StIdReq,
    StWaitId,
    StFill,
    StReq,
    StSend
  } fmt_state_e;

  // Select 0..3 -> 4,8,16,32; selects 4..7 saturate to 32.
  function automatic logic [5:0] len_map(input logic [2:0] sel);
    logic [5:0] len;
    case (sel)
      3'd0:    len = 6'd4;
      3'd1:    len = 6'd8;
      3'd2:    len = 6'd16;
      default: len = 6'd32;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/fmt_pkt_buf.sv
// Packet buffer: synchronous write, combinational read. Contents are not reset.
module fmt_pkt_buf #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned Depth  = 32,
  localparam int unsigned AW    = $clog2(Depth)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/formatter.sv
// Packet formatter: fetches a channel from the arbiter, buffers one packet, then
// bursts it downstream after a request/grant handshake.
module formatter #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MAX_LEN = 32
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              a2f_val_i,
  input  logic [1:0]        a2f_id_i,
  input  logic [DATA_W-1:0] a2f_data_i,
  input  logic [2:0]        a2f_pkglen_sel_i,
  output logic              f2a_id_req_o,
  output logic              f2a_ack_o,
  input  logic              fmt_grant_i,
  output logic              fmt_req_o,
  output logic [1:0]        fmt_chid_o,
  output logic [5:0]        fmt_length_o,
  output logic [DATA_W-1:0] fmt_data_o,
  output logic              fmt_start_o,
  output logic              fmt_end_o
);

  import formatter_pkg::*;

  localparam int unsigned AW = $clog2(MAX_LEN);

  fmt_state_e        state_q, state_d;
  logic [1:0]        chid_q, chid_d;
  logic [5:0]        len_q, len_d;
  logic [5:0]        wcnt_q, wcnt_d;
  logic [5:0]        rcnt_q, rcnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              start_q, start_d;
  logic              end_q, end_d;
  logic              buf_we;
  logic [DATA_W-1:0] buf_rdata;

  fmt_pkt_buf #(
    .DATA_W (DATA_W),
    .Depth  (MAX_LEN)
  ) u_buf (
    .clk_i   (clk_i),
    .we_i    (buf_we),
    .waddr_i (wcnt_q[AW-1:0]),
    .wdata_i (a2f_data_i),
    .raddr_i (rcnt_q[AW-1:0]),
    .rdata_o (buf_rdata)
  );

  always_comb begin
    state_d = state_q;
    chid_d  = chid_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = '0;
    data_d  = '0;
    start_d = 1'b0;
    end_d   = 1'b0;
    buf_we  = 1'b0;
    case (state_q)
      StIdle:  state_d = StIdReq;
      StIdReq: state_d = StWaitId;
      StWaitId: begin
        if (a2f_id_i == NO_CH) begin
          state_d = StIdReq;
        end else begin
          chid_d  = a2f_id_i;
          len_d   = len_map(a2f_pkglen_sel_i);
          wcnt_d  = '0;
          state_d = StFill;
        end
      end
      StFill: begin
        if (a2f_val_i) begin
          buf_we = 1'b1;
          wcnt_d = wcnt_q + 6'd1;
          if (wcnt_q == len_q - 6'd1) begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        // Word 0 is registered on the grant edge so it appears as req drops.
        if (fmt_grant_i) begin
          data_d  = buf_rdata;
          start_d = 1'b1;
          rcnt_d  = 6'd1;
          state_d = StSend;
        end
      end
      StSend: begin
        if (rcnt_q == len_q) begin
          state_d = StIdReq;
        end else begin
          data_d = buf_rdata;
          end_d  = (rcnt_q == len_q - 6'd1);
          rcnt_d = rcnt_q + 6'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= StIdle;
      chid_q  <= '0;
      len_q   <= '0;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      chid_q  <= chid_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      data_q  <= data_d;
      start_q <= start_d;
      end_q   <= end_d;
    end
  end

  assign f2a_id_req_o = (state_q == StIdReq);
  assign f2a_ack_o    = (state_q == StFill);
  assign fmt_req_o    = (state_q == StReq);
  assign fmt_chid_o   = chid_q;
  assign fmt_length_o = len_q;
  assign fmt_data_o   = data_q;
  assign fmt_start_o  = start_q;
  assign fmt_end_o    = end_q;

endmodule

// File: tb/tb_formatter.sv
// Self-checking bench for formatter: table-driven and random packets against a
// queue-based reference, plus a mid-fill reset sequence.
module tb_formatter;

  localparam int unsigned DATA_W = 32;
  localparam logic [1:0]  NONE   = 2'b11;

  logic              clk_i = 1'b0;
  logic              rstn_i;
  logic              a2f_val_i;
  logic [1:0]        a2f_id_i;
  logic [DATA_W-1:0] a2f_data_i;
  logic [2:0]        a2f_pkglen_sel_i;
  logic              f2a_id_req_o;
  logic              f2a_ack_o;
  logic              fmt_grant_i;
  logic              fmt_req_o;
  logic [1:0]        fmt_chid_o;
  logic [5:0]        fmt_length_o;
  logic [DATA_W-1:0] fmt_data_o;
  logic              fmt_start_o;
  logic              fmt_end_o;

  int n_checks = 0;
  int n_errors = 0;

  formatter #(
    .DATA_W  (DATA_W),
    .MAX_LEN (32)
  ) dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .a2f_val_i        (a2f_val_i),
    .a2f_id_i         (a2f_id_i),
    .a2f_data_i       (a2f_data_i),
    .a2f_pkglen_sel_i (a2f_pkglen_sel_i),
    .f2a_id_req_o     (f2a_id_req_o),
    .f2a_ack_o        (f2a_ack_o),
    .fmt_grant_i      (fmt_grant_i),
    .fmt_req_o        (fmt_req_o),
    .fmt_chid_o       (fmt_chid_o),
    .fmt_length_o     (fmt_length_o),
    .fmt_data_o       (fmt_data_o),
    .fmt_start_o      (fmt_start_o),
    .fmt_end_o        (fmt_end_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int         nones;
    logic [1:0] id;
    logic [2:0] sel;
    int         bubble;
    int         gdly;
    bit         gfill;
    int         exp_len;
  } vec_t;

  vec_t vecs[8];

  function automatic int ref_len(input logic [2:0] sel);
    return (sel >= 3'd3) ? 32 : (4 << sel);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string name);
    check(name, {f2a_id_req_o, f2a_ack_o, fmt_req_o, fmt_chid_o, fmt_length_o,
                 fmt_data_o, fmt_start_o, fmt_end_o}, 64'd0);
  endtask

  // Answers each ID request (NONE for the first nones), ends in the first FILL cycle.
  task automatic start_fill(input int nones, input logic [1:0] id, input logic [2:0] sel);
    for (int a = 0; a <= nones; a++) begin
      int cyc = 0;
      while (!f2a_id_req_o && cyc < 50) begin
        @(negedge clk_i);
        cyc++;
      end
      check("idreq_seen", f2a_id_req_o, 1);
      if (a > 0) check("idreq_retry_gap", cyc, 1);
      a2f_id_i         = (a < nones) ? NONE : id;
      a2f_pkglen_sel_i = sel;
      @(negedge clk_i);
      check("idreq_one_cycle", f2a_id_req_o, 0);
      check("no_ack_wait_id", f2a_ack_o, 0);
    end
    @(negedge clk_i);
    check("ack_in_fill", f2a_ack_o, 1);
  endtask

  task automatic run_packet(input int nones, input logic [1:0] id, input logic [2:0] sel,
                            input int bubble, input int gdly, input bit gfill,
                            input int exp_len);
    logic [DATA_W-1:0] q[$];
    int cnt = 0;
    int budget = 0;
    int ack_err = 0;
    int st_err = 0;
    int berr = 0;
    bit gsent = 0;
    start_fill(nones, id, sel);
    while (cnt < exp_len && budget < 2000) begin
      a2f_val_i   = ($urandom_range(99) >= bubble);
      a2f_data_i  = $urandom;
      fmt_grant_i = gfill && !gsent && (cnt >= exp_len / 2);
      if (fmt_grant_i) gsent = 1;
      if (!f2a_ack_o || fmt_req_o) ack_err++;
      if (a2f_val_i && f2a_ack_o) begin
        q.push_back(a2f_data_i);
        cnt++;
      end
      @(negedge clk_i);
      budget++;
    end
    fmt_grant_i = 1'b0;
    a2f_val_i   = 1'b1;
    a2f_data_i  = $urandom;
    check("fill_beats", cnt, exp_len);
    check("fill_ack_held", ack_err, 0);
    check("no_extra_ack", f2a_ack_o, 0);
    check("req_after_fill", fmt_req_o, 1);
    check("req_chid", fmt_chid_o, id);
    check("req_length", fmt_length_o, exp_len);
    for (int i = 0; i < gdly; i++) begin
      if (!fmt_req_o || f2a_ack_o || f2a_id_req_o || fmt_chid_o !== id ||
          fmt_length_o !== 6'(exp_len) || fmt_start_o || fmt_data_o !== '0) st_err++;
      @(negedge clk_i);
    end
    check("req_hold", st_err, 0);
    check("req_before_grant", {fmt_req_o, fmt_start_o}, 2'b10);
    fmt_grant_i = 1'b1;
    @(negedge clk_i);
    fmt_grant_i = 1'b0;
    check("req_dropped", fmt_req_o, 0);
    check("burst_start", fmt_start_o, 1);
    for (int i = 0; i < exp_len; i++) begin
      if (fmt_data_o !== q[i] || fmt_start_o !== (i == 0) || fmt_end_o !== (i == exp_len - 1) ||
          fmt_req_o || f2a_ack_o || f2a_id_req_o || fmt_chid_o !== id ||
          fmt_length_o !== 6'(exp_len)) berr++;
      @(negedge clk_i);
    end
    check("burst_words", berr, 0);
    check("idreq_after_end", f2a_id_req_o, 1);
    check("idle_after_burst", {fmt_data_o, fmt_start_o, fmt_end_o}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 2'd0, 3'd0, 0,  2,  1'b0, 4};
    vecs[1] = '{0, 2'd1, 3'd3, 30, 1,  1'b0, 32};
    vecs[2] = '{3, 2'd2, 3'd5, 0,  0,  1'b0, 32};
    vecs[3] = '{0, 2'd1, 3'd1, 0,  20, 1'b0, 8};
    vecs[4] = '{0, 2'd0, 3'd2, 20, 3,  1'b1, 16};
    vecs[5] = '{1, 2'd2, 3'd4, 10, 0,  1'b0, 32};
    vecs[6] = '{0, 2'd1, 3'd6, 0,  1,  1'b1, 32};
    vecs[7] = '{0, 2'd0, 3'd7, 25, 4,  1'b0, 32};

    rstn_i           = 1'b0;
    a2f_val_i        = 1'b0;
    a2f_id_i         = NONE;
    a2f_data_i       = '0;
    a2f_pkglen_sel_i = '0;
    fmt_grant_i      = 1'b0;
    repeat (3) @(negedge clk_i);
    check_zero("reset_state");
    rstn_i = 1'b1;

    foreach (vecs[i]) begin
      run_packet(vecs[i].nones, vecs[i].id, vecs[i].sel, vecs[i].bubble, vecs[i].gdly,
                 vecs[i].gfill, vecs[i].exp_len);
    end

    for (int i = 0; i < 6; i++) begin
      logic [2:0] sel = 3'($urandom_range(0, 7));
      run_packet($urandom_range(0, 2), 2'($urandom_range(0, 2)), sel, $urandom_range(0, 40),
                 $urandom_range(0, 5), 1'($urandom_range(0, 1)), ref_len(sel));
    end

    // Abort a 16-word packet after five accepted beats.
    begin
      int se_err = 0;
      start_fill(0, 2'd1, 3'd2);
      for (int i = 0; i < 5; i++) begin
        a2f_val_i  = 1'b1;
        a2f_data_i = $urandom;
        @(negedge clk_i);
      end
      a2f_val_i = 1'b0;
      a2f_id_i  = NONE;
      rstn_i    = 1'b0;
      #1;
      check_zero("reset_mid_fill");
      @(negedge clk_i);
      rstn_i = 1'b1;
      #1;
      check_zero("idle_after_release");
      for (int i = 0; i < 6; i++) begin
        @(negedge clk_i);
        if (fmt_start_o || fmt_end_o || fmt_req_o) se_err++;
        if (i == 0) check("idreq_after_reset", f2a_id_req_o, 1);
      end
      check("no_stale_frame", se_err, 0);
    end

    run_packet(0, 2'd2, 3'd0, 10, 1, 1'b0, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/formatter.md
# formatter

Packet formatter stage directly downstream of the channel arbiter. It requests a channel grant from the arbiter, then collects one packet of the selected channel's data words into a local buffer. The packet length comes from the arbiter's length select. Once the packet is complete, the block handshakes with the downstream consumer and streams the packet as a contiguous burst, framed by channel id, length, start and end.

## Interface
Parameters:
- DATA_W, 32, data word width
- MAX_LEN, 32, buffer depth in words; equals the largest packet length

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- a2f_val_i  in  1  arbiter data valid (selected slave's valid)
- a2f_id_i  in  2  arbiter selected channel; 2'b11 = none
- a2f_data_i  in  DATA_W  arbiter data
- a2f_pkglen_sel_i  in  3  packet length select of the selected channel
- f2a_id_req_o  out  1  request to the arbiter to (re)select a channel
- f2a_ack_o  out  1  acknowledge; a beat transfers when a2f_val_i & f2a_ack_o
- fmt_grant_i  in  1  downstream grant
- fmt_req_o  out  1  downstream request; a full packet is buffered
- fmt_chid_o  out  2  channel id of the buffered packet
- fmt_length_o  out  6  packet length in words (4..32)
- fmt_data_o  out  DATA_W  burst data
- fmt_start_o  out  1  first word of the burst
- fmt_end_o  out  1  last word of the burst

## Operation
- Length map for a2f_pkglen_sel_i: 0→4, 1→8, 2→16, 3→32. Values 4..7 map to 32.
- FSM states: IDLE, ID_REQ, WAIT_ID, FILL, REQ, SEND.
- IDLE: the reset state. Moves to ID_REQ unconditionally on the next cycle.
- ID_REQ: f2a_id_req_o=1 for exactly one cycle. The arbiter registers its selection on this edge. Then WAIT_ID.
- WAIT_ID: sample a2f_id_i.
  - 2'b11 → back to ID_REQ.
  - Otherwise latch chid_r=a2f_id_i and len_r=map(a2f_pkglen_sel_i), clear wcnt, go to FILL.
- FILL: f2a_ack_o=1 (combinational decode of state).
  - Each accepted beat writes buf[wcnt] and increments wcnt. Bubbles (a2f_val_i=0) are tolerated indefinitely.
  - The beat accepted at wcnt==len_r-1 → REQ. f2a_ack_o=0 from the next cycle, so no extra beat is taken.
- REQ: fmt_req_o=1, with fmt_chid_o=chid_r and fmt_length_o=len_r held stable.
  - When fmt_grant_i is sampled 1 → SEND, clear rcnt.
  - Grant while not in REQ is ignored.
- SEND: one word per cycle, no stall allowed downstream.
  - fmt_data_o<=buf[rcnt] and rcnt increments.
  - fmt_start_o=1 with word 0. fmt_end_o=1 with word len_r-1.
  - After the last word → ID_REQ.
- f2a_id_req_o and f2a_ack_o are never asserted in REQ or SEND. The arbiter selection therefore stays frozen until the next ID_REQ.
- fmt_data_o is 0 whenever no burst word is being driven.
- fmt_chid_o and fmt_length_o hold their values from REQ through the end of SEND. They reset to 0.

## Timing
- Reset values:
  - state=IDLE.
  - All outputs 0: f2a_id_req_o, f2a_ack_o, fmt_req_o, fmt_chid_o, fmt_length_o, fmt_data_o, fmt_start_o, fmt_end_o.
  - Counters 0. Buffer contents are don't-care.
- Reset asserted mid-operation aborts immediately to IDLE. The partial packet is discarded and no end is emitted.
- Cycle timing relative to the ID request:
  - ID_REQ in cycle t; selection is sampled in cycle t+1 (WAIT_ID).
  - Earliest first accepted beat is cycle t+2.
- Cycle timing relative to the grant:
  - Grant sampled at edge k.
  - fmt_req_o low from cycle k+1.
  - Words appear in cycles k+1 .. k+len_r; start at k+1, end at k+len_r.
  - ID_REQ follows in cycle k+len_r+1.
- Minimum length is 4, so start and end never coincide.
- fmt_data_o, fmt_start_o and fmt_end_o are registered outputs. f2a_id_req_o, f2a_ack_o and fmt_req_o are decoded from the state register (glitch-free).
- wcnt and rcnt are 6 bits and never wrap; they are bounded by len_r ≤ MAX_LEN.

## Structure
- Package formatter_pkg contains:
  - state enum
  - MAX_LEN
  - length-map function (3-bit select → 6-bit length)
  - NO_CH = 2'b11
- Sub-module fmt_pkt_buf: MAX_LEN×DATA_W register array with a synchronous write port and a combinational read port. The read data is registered in the formatter.

## Test plan
- Single channel, sel=0, 4 back-to-back beats A0..A3, grant 2 cycles after req → chid=0, length=4, burst A0..A3 with start on A0 and end on A3.
- sel=3 with random val bubbles during FILL → exactly 32 words are accepted, no 33rd ack, burst of 32 contiguous words.
- a2f_id_i=2'b11 in WAIT_ID three times, then id=2 with sel=5 → ID_REQ repeats each time; packet then carries chid=2, length=32.
- fmt_grant_i held 0 for 20 cycles in REQ → req held, f2a_ack_o=0, chid and length stable; burst starts the cycle after grant.
- Reset pulsed at FILL beat 5 of a 16-word packet → all outputs 0. After release: IDLE, then ID_REQ, and no start or end from the aborted packet.
- Grant pulsed during FILL → ignored; burst starts only after REQ plus grant.
